// File: rtl/density_accumulator.sv
// Sums a stream of binary16 kernel contributions into one density value.
// Terms are buffered in a FIFO and folded in one at a time through a pipelined adder.
module density_accumulator #(
  parameter int unsigned COUNT_W    = 8,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic               clk_in,
  input  logic               rst,
  input  logic               start,
  input  logic [COUNT_W-1:0] num_terms,
  input  logic [15:0]        term,
  input  logic               data_valid_in,
  output logic [15:0]        result,
  output logic               data_valid_out,
  output logic               busy,
  output logic               overflow
);

  localparam int unsigned PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W   = PTR_W + 1;
  localparam int unsigned ADD_LAT = 4;

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t             state, state_nxt;
  logic [COUNT_W-1:0] n_q, recv_q, consumed_q;
  logic [15:0]        fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   head_q, tail_q;
  logic [CNT_W-1:0]   count_q;
  logic [15:0]        acc_q;
  logic               in_flight_q;
  logic [15:0]        add_sum;
  logic               add_valid;

  logic start_ok_c, push_c, drop_c, pop_c, last_c, fifo_full_c, limit_hit_c;

  always_ff @(posedge clk_in) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state plus term acceptance / issue decisions
  always_comb begin
    state_nxt   = state;
    push_c      = 1'b0;
    drop_c      = 1'b0;
    pop_c       = (state == ACCUM) && !in_flight_q && (count_q != '0);
    last_c      = (state == ACCUM) && add_valid && ((consumed_q + COUNT_W'(1)) == n_q);
    start_ok_c  = (state == IDLE) && start;
    fifo_full_c = (count_q == CNT_W'(FIFO_DEPTH)) && !pop_c;
    limit_hit_c = start_ok_c ? (num_terms == '0) : (recv_q == n_q);
    if (data_valid_in && (start_ok_c || (state == ACCUM))) begin
      if (limit_hit_c || fifo_full_c) drop_c = 1'b1;
      else                            push_c = 1'b1;
    end
    case (state)
      IDLE:    if (start) state_nxt = (num_terms == '0) ? DONE : ACCUM;
      ACCUM:   if (last_c) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (push_c) fifo_mem[tail_q] <= term;
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_c) tail_q <= tail_q + PTR_W'(1);
      if (pop_c)  head_q <= head_q + PTR_W'(1);
      case ({push_c, pop_c})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      n_q            <= '0;
      recv_q         <= '0;
      consumed_q     <= '0;
      acc_q          <= '0;
      in_flight_q    <= 1'b0;
      result         <= '0;
      data_valid_out <= 1'b0;
      busy           <= 1'b0;
      overflow       <= 1'b0;
    end else begin
      data_valid_out <= 1'b0;
      busy           <= (state_nxt != IDLE);
      if (start_ok_c) begin
        n_q        <= num_terms;
        acc_q      <= '0;
        consumed_q <= '0;
        overflow   <= 1'b0;
        recv_q     <= push_c ? COUNT_W'(1) : '0;
      end else if (push_c) begin
        recv_q <= recv_q + COUNT_W'(1);
      end
      // A drop in the start cycle must win over the start's clear
      if (drop_c) overflow <= 1'b1;
      if (pop_c)  in_flight_q <= 1'b1;
      if ((state == ACCUM) && add_valid) begin
        acc_q       <= add_sum;
        consumed_q  <= consumed_q + COUNT_W'(1);
        in_flight_q <= 1'b0;
      end
      if (state == DONE) begin
        result         <= acc_q;
        data_valid_out <= 1'b1;
      end
    end
  end

  binary16_adder #(.LATENCY(ADD_LAT)) u_adder (
    .clk_in         (clk_in),
    .rst            (rst),
    .a              (acc_q),
    .b              (fifo_mem[head_q]),
    .data_valid_in  (pop_c),
    .result         (add_sum),
    .data_valid_out (add_valid)
  );

endmodule

// binary16 adder, round-to-nearest-even, subnormal aware; LATENCY output stages
// are left for retiming the single combinational add.
module binary16_adder #(
  parameter int unsigned LATENCY = 4
) (
  input  logic        clk_in,
  input  logic        rst,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        data_valid_in,
  output logic [15:0] result,
  output logic        data_valid_out
);

  logic        sx, sy;
  logic [4:0]  ex, ey;
  logic [9:0]  fx, fy;
  logic [5:0]  e_big, e_sml, diff, e_n, lsh;
  logic [13:0] m_big, m_sml, aligned, sn;
  logic [45:0] sh;
  logic [14:0] s, packed_v;
  logic [4:0]  exp_field;
  logic [3:0]  lz;
  logic        rnd;
  logic [15:0] sum_c;

  logic [15:0]        pipe_sum [LATENCY];
  logic [LATENCY-1:0] pipe_v;

  // Order operands so x has the larger magnitude, then align, add, normalise, round
  always_comb begin
    {sx, ex, fx} = (a[14:0] < b[14:0]) ? b : a;
    {sy, ey, fy} = (a[14:0] < b[14:0]) ? a : b;
    e_big   = {1'b0, (ex == 5'd0) ? 5'd1 : ex};
    e_sml   = {1'b0, (ey == 5'd0) ? 5'd1 : ey};
    m_big   = {(ex != 5'd0), fx, 3'b000};
    m_sml   = {(ey != 5'd0), fy, 3'b000};
    diff    = e_big - e_sml;
    sh      = {m_sml, 32'd0} >> diff;
    aligned = sh[45:32] | {13'd0, |sh[31:0]};
    s       = (sx == sy) ? ({1'b0, m_big} + {1'b0, aligned})
                         : ({1'b0, m_big} - {1'b0, aligned});
    lz = 4'd14;
    for (int i = 0; i < 14; i++) begin
      if (s[i]) lz = 4'(13 - i);
    end
    lsh = '0;
    if (s[14]) begin
      sn  = {s[14:2], s[1] | s[0]};
      e_n = e_big + 6'd1;
    end else begin
      lsh = ({2'b00, lz} < (e_big - 6'd1)) ? {2'b00, lz} : (e_big - 6'd1);
      sn  = s[13:0] << lsh;
      e_n = e_big - lsh;
    end
    exp_field = sn[13] ? e_n[4:0] : 5'd0;
    rnd       = sn[2] & (sn[1] | sn[0] | sn[3]);
    // Rounding carry ripples into the exponent (subnormal->normal, normal->inf)
    packed_v  = {exp_field, sn[12:3]} + 15'(rnd);
    sum_c     = {sx, packed_v};
    if (s == '0)         sum_c = {sx & sy, 15'd0};
    if (e_n >= 6'd31)    sum_c = {sx, 15'h7C00};
    if (ex == 5'h1f) begin
      if (fx != '0 || (ey == 5'h1f && sx != sy)) sum_c = 16'h7E00;
      else                                       sum_c = {sx, 15'h7C00};
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      pipe_v <= '0;
      for (int i = 0; i < int'(LATENCY); i++) pipe_sum[i] <= '0;
    end else begin
      pipe_v[0]   <= data_valid_in;
      pipe_sum[0] <= sum_c;
      for (int i = 1; i < int'(LATENCY); i++) begin
        pipe_v[i]   <= pipe_v[i-1];
        pipe_sum[i] <= pipe_sum[i-1];
      end
    end
  end

  assign result         = pipe_sum[LATENCY-1];
  assign data_valid_out = pipe_v[LATENCY-1];

endmodule
